wb_arbiter: RTL

Writeback arbiter for the integer back end. It shares the single register-file write port, and the writeBackBuffer scoreboard set port, among NREQ execution units: ALU, BRU, JAL, LSU and others. Each unit offers at most one result per cycle, and the arbiter grants one per cycle in round-robin order. The granted result goes into a one-deep output register that writes regFileX and marks the renamed destination ready for the issue buffers' RAW checks.

---
 rtl/wb_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter for the integer register-file write port
//
// Grants at most one of NREQ execution-unit results per cycle and registers it
// into a one-deep output stage that drives the register-file write port and the
// writeBackBuffer scoreboard set vector.
//
// Ports:
//   CLK        clock, rising edge
//   RSTn       asynchronous active-low reset
//   req_vaild  [NREQ]            per-unit result valid
//   req_ready  [NREQ]            per-unit grant, combinational, one-hot or zero
//   req_rd0    [(5+RNBIT)*NREQ]  per-unit destination {arch, rn}, unit i at slice i
//   req_res    [DW*NREQ]         per-unit result data, unit i at slice i
//   flush      pipeline flush: blocks grants, kills the output register
//   wb_vaild   registered register-file write enable
//   wb_rd0     [5+RNBIT]         registered write index
//   wb_res     [DW]              registered write data
//   wb_mark    [32*2^RNBIT]      one-hot scoreboard set vector (1 << wb_rd0 when valid)

module wb_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 64,
    parameter int RNBIT = 2
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [NREQ-1:0]             req_vaild,
    output logic [NREQ-1:0]             req_ready,
    input  logic [(5+RNBIT)*NREQ-1:0]   req_rd0,
    input  logic [DW*NREQ-1:0]          req_res,
    input  logic                        flush,
    output logic                        wb_vaild,
    output logic [5+RNBIT-1:0]          wb_rd0,
    output logic [DW-1:0]               wb_res,
    output logic [32*(2**RNBIT)-1:0]    wb_mark
);

    localparam int IW = 5 + RNBIT;
    localparam int MW = 32 * (2 ** RNBIT);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic          grant_found;
    logic          grant;
    logic [PW-1:0] rr_ptr_next;

    logic [IW-1:0] rd_arr  [NREQ];
    logic [DW-1:0] res_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rd_arr[i]  = req_rd0[i*IW +: IW];
        assign res_arr[i] = req_res[i*DW +: DW];
    end

    // Scan rr_ptr, rr_ptr+1, ... modulo NREQ; the first valid unit wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_found && req_vaild[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PW-1:0];
            end
        end
    end

    // Flush masks every grant so nothing is consumed while the pipe is killed.
    assign grant = grant_found && !flush;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rr_ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rr_ptr   <= '0;
            wb_vaild <= 1'b0;
            wb_rd0   <= '0;
            wb_res   <= '0;
        end else if (flush) begin
            rr_ptr   <= '0;
            wb_vaild <= 1'b0;
        end else if (grant) begin
            rr_ptr   <= rr_ptr_next;
            wb_rd0   <= rd_arr[grant_idx];
            wb_res   <= res_arr[grant_idx];
            // Writes to x0 are consumed but never reach the register file.
            wb_vaild <= (rd_arr[grant_idx][IW-1:RNBIT] != 5'd0);
        end else begin
            wb_vaild <= 1'b0;
        end
    end

    assign wb_mark = wb_vaild ? (MW'(1) << wb_rd0) : '0;

endmodule
